// File: rtl/cpld_uart_pkg.sv
// cpld_uart_pkg: shared encodings for the CPLD UART bus-cycle controller.
// Used by cpld_uart_ctrl and, when CPLD_UART_RXBUF_EN is defined, by uart_rx_fifo.
package cpld_uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_STAT      = 4'd1,
        ST_RD_LOW    = 4'd2,
        ST_WR_SETUP  = 4'd3,
        ST_WR_LOW    = 4'd4,
        ST_WR_HOLD   = 4'd5,
        ST_WAIT_TBRE = 4'd6,
        ST_WAIT_TSRE = 4'd7,
        ST_DONE      = 4'd8
    } state_t;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    localparam int STAT_WRITABLE = 0;
    localparam int STAT_READABLE = 1;

    localparam int RXFIFO_DEPTH = 4;

    function automatic logic [7:0] status_byte(input logic readable, input logic writable);
        logic [7:0] v;
        v                = 8'h00;
        v[STAT_READABLE] = readable;
        v[STAT_WRITABLE] = writable;
        return v;
    endfunction

endpackage

// File: rtl/cpld_uart_ctrl_fifo.sv
// uart_rx_fifo: small receive FIFO with wrap-bit pointers, asynchronous active-high reset.
// Only compiled when CPLD_UART_RXBUF_EN is defined.
`ifdef CPLD_UART_RXBUF_EN
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // storage array
    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    // read/write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/cpld_uart_ctrl.sv
// cpld_uart_ctrl: request/ack bus-cycle controller for the CPLD UART sharing BaseRAM data[7:0].
// Define CPLD_UART_RXBUF_EN to add a 4-entry receive FIFO filled by autonomous reads.
module cpld_uart_ctrl
    import cpld_uart_pkg::*;
#(
    parameter int RD_LOW_CYCLES = 2,
    parameter int WR_LOW_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       we,
    input  logic       addr_sel,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    output logic       busy,
    output logic       ram_inhibit,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_dataready,
    input  logic       uart_tbre,
    input  logic       uart_tsre
);
    localparam logic [2:0] RD_RELOAD = 3'(RD_LOW_CYCLES - 1);
    localparam logic [2:0] WR_RELOAD = 3'(WR_LOW_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic [1:0] r_dr_sync, r_tbre_sync, r_tsre_sync;
    logic       w_dr_s, w_tbre_s, w_tsre_s;
    logic       w_accept, w_rd_last, w_auto_go;
    logic [7:0] w_stat_rdata;
    logic [7:0] r_rdata, r_bus_out;
    logic       r_ack, r_busy, r_ram_inhibit, r_bus_oe, r_uart_rdn, r_uart_wrn;

    assign w_dr_s    = r_dr_sync[1];
    assign w_tbre_s  = r_tbre_sync[1];
    assign w_tsre_s  = r_tsre_sync[1];
    assign w_accept  = (r_state == ST_IDLE) && req;
    assign w_rd_last = (r_state == ST_RD_LOW) && (r_cnt == 3'd0);

`ifdef CPLD_UART_RXBUF_EN
    // Data reads are served from the FIFO; RD_LOW only ever refills it.
    localparam state_t DATA_RD_STATE = ST_STAT;
    localparam state_t RD_EXIT_STATE = ST_IDLE;

    logic       r_pop;
    logic [1:0] r_holdoff;
    logic       w_fifo_full, w_fifo_empty, w_fifo_pop;
    logic [7:0] w_fifo_dout;

    assign w_fifo_pop   = (r_state == ST_STAT) && r_pop;
    assign w_auto_go    = w_dr_s && !w_fifo_full && (r_holdoff == 2'd0);
    assign w_stat_rdata = r_pop ? (w_fifo_empty ? 8'h00 : w_fifo_dout)
                                : status_byte(!w_fifo_empty, w_tbre_s & w_tsre_s);

    uart_rx_fifo #(.DEPTH(RXFIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rd_last),
        .i_din   (bus_in),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The holdoff covers the synchronizer lag so a stale dr_s cannot trigger a duplicate read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop     <= 1'b0;
            r_holdoff <= 2'd0;
        end else begin
            if (w_accept) begin
                r_pop <= (addr_sel == ADDR_DATA) && !we;
            end
            if (w_rd_last) begin
                r_holdoff <= 2'd2;
            end else if ((r_state == ST_IDLE) && (r_holdoff != 2'd0)) begin
                r_holdoff <= r_holdoff - 2'd1;
            end
        end
    end
`else
    localparam state_t DATA_RD_STATE = ST_RD_LOW;
    localparam state_t RD_EXIT_STATE = ST_DONE;

    assign w_auto_go    = 1'b0;
    assign w_stat_rdata = status_byte(w_dr_s, w_tbre_s & w_tsre_s);
`endif

    // two-flop synchronizers for the asynchronous CPLD status lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr_sync   <= 2'b00;
            r_tbre_sync <= 2'b00;
            r_tsre_sync <= 2'b00;
        end else begin
            r_dr_sync   <= {r_dr_sync[0], uart_dataready};
            r_tbre_sync <= {r_tbre_sync[0], uart_tbre};
            r_tsre_sync <= {r_tsre_sync[0], uart_tsre};
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (addr_sel == ADDR_STAT) begin
                        w_next = ST_STAT;
                    end else if (we) begin
                        w_next = ST_WR_SETUP;
                    end else begin
                        w_next = DATA_RD_STATE;
                    end
                end else if (w_auto_go) begin
                    w_next = ST_RD_LOW;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_STAT:      w_next = ST_IDLE;
            ST_RD_LOW:    w_next = (r_cnt == 3'd0) ? RD_EXIT_STATE : ST_RD_LOW;
            ST_WR_SETUP:  w_next = ST_WR_LOW;
            ST_WR_LOW:    w_next = (r_cnt == 3'd0) ? ST_WR_HOLD : ST_WR_LOW;
            ST_WR_HOLD:   w_next = ST_WAIT_TBRE;
            ST_WAIT_TBRE: w_next = w_tbre_s ? ST_WAIT_TSRE : ST_WAIT_TBRE;
            ST_WAIT_TSRE: w_next = w_tsre_s ? ST_DONE : ST_WAIT_TSRE;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // state register, strobe-width counter and registered outputs decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 3'd0;
            r_rdata       <= 8'h00;
            r_bus_out     <= 8'h00;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_ram_inhibit <= 1'b0;
            r_bus_oe      <= 1'b0;
            r_uart_rdn    <= 1'b1;
            r_uart_wrn    <= 1'b1;
        end else begin
            r_state       <= w_next;
            r_busy        <= (w_next != ST_IDLE);
            r_ram_inhibit <= (w_next != ST_IDLE);
            r_uart_rdn    <= (w_next != ST_RD_LOW);
            r_uart_wrn    <= (w_next != ST_WR_LOW);
            r_bus_oe      <= (w_next == ST_WR_SETUP) || (w_next == ST_WR_LOW) || (w_next == ST_WR_HOLD);
            r_ack         <= (r_state == ST_STAT) || (r_state == ST_DONE);

            if ((w_next == ST_RD_LOW) && (r_state != ST_RD_LOW)) begin
                r_cnt <= RD_RELOAD;
            end else if ((w_next == ST_WR_LOW) && (r_state != ST_WR_LOW)) begin
                r_cnt <= WR_RELOAD;
            end else if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_accept && we) begin
                r_bus_out <= wdata;
            end

            if (r_state == ST_STAT) begin
                r_rdata <= w_stat_rdata;
            end else if (w_rd_last) begin
                r_rdata <= bus_in;
            end
        end
    end

    assign rdata       = r_rdata;
    assign ack         = r_ack;
    assign busy        = r_busy;
    assign ram_inhibit = r_ram_inhibit;
    assign bus_out     = r_bus_out;
    assign bus_oe      = r_bus_oe;
    assign uart_rdn    = r_uart_rdn;
    assign uart_wrn    = r_uart_wrn;

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// tb_cpld_uart_ctrl: directed, table-driven bench for cpld_uart_ctrl (RD/WR_LOW_CYCLES = 2).
// With CPLD_UART_RXBUF_EN defined it exercises the receive-FIFO build instead.
module tb_cpld_uart_ctrl;
    logic       clk = 1'b0;
    logic       rst, req, we, addr_sel;
    logic [7:0] wdata, rdata, bus_in, bus_out;
    logic       ack, busy, ram_inhibit, bus_oe, uart_rdn, uart_wrn;
    logic       uart_dataready, uart_tbre, uart_tsre;

    always #5 clk = ~clk;

    cpld_uart_ctrl #(.RD_LOW_CYCLES(2), .WR_LOW_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_sel(addr_sel), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .ram_inhibit(ram_inhibit),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One request/ack transaction; counts strobe cycles and checks bus framing on the way.
    task automatic run_txn(input logic t_we, input logic t_addr, input logic [7:0] t_wdata,
                           input int tbre_at, input int tsre_at,
                           output int lat, output int rdn_n, output int wrn_n,
                           output logic [7:0] rd, output logic frame_ok);
        int oe_first, oe_last, wrn_first, wrn_last, oe_n;
        lat = -1; rdn_n = 0; wrn_n = 0; rd = 8'h00; frame_ok = 1'b1;
        oe_first = -1; oe_last = -1; wrn_first = -1; wrn_last = -1; oe_n = 0;
        req = 1'b1; we = t_we; addr_sel = t_addr; wdata = t_wdata;
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!uart_rdn) rdn_n++;
            if (!uart_wrn) begin
                wrn_n++;
                if (wrn_first < 0) wrn_first = c;
                wrn_last = c;
            end
            if (bus_oe) begin
                oe_n++;
                if (oe_first < 0) oe_first = c;
                oe_last = c;
                if (bus_out !== t_wdata) frame_ok = 1'b0;
            end
            if (ack) begin
                lat = c;
                rd  = rdata;
                if (busy || ram_inhibit) frame_ok = 1'b0;
                break;
            end
            if (!busy || !ram_inhibit) frame_ok = 1'b0;
            if (c == tbre_at) uart_tbre = 1'b1;
            if (c == tsre_at) uart_tsre = 1'b1;
        end
        req = 1'b0;
        if (t_we && !t_addr) begin
            if ((oe_first != wrn_first - 1) || (oe_last != wrn_last + 1)) frame_ok = 1'b0;
        end else if (oe_n != 0) begin
            frame_ok = 1'b0;
        end
    endtask

    typedef struct {
        logic       we, addr_sel;
        logic [7:0] wdata, bus_in;
        logic       dr, tbre, tsre;
        int         tbre_at, tsre_at;
        int         exp_lat, exp_rdn, exp_wrn;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int         lat, rdn_n, wrn_n, cnt;
    logic [7:0] rd;
    logic       ok;

`ifdef CPLD_UART_RXBUF_EN
    logic [7:0] fifo_bytes [5];
    int         idx, pulses;
    logic       prev_rdn;
`endif

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr_sel = 1'b0; wdata = 8'h00; bus_in = 8'h00;
        uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset strobes/flags", {uart_rdn, uart_wrn, bus_oe, ack, busy, ram_inhibit}, 6'b110000);
        check("reset bus_out", bus_out, 8'h00);
        check("reset rdata", rdata, 8'h00);
        rst = 1'b0;

`ifdef CPLD_UART_RXBUF_EN
        fifo_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        idx = 0; pulses = 0; prev_rdn = 1'b1; cnt = 0;
        uart_tbre = 1'b1; uart_tsre = 1'b1;
        bus_in = fifo_bytes[0]; uart_dataready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ack) cnt++;
            if (prev_rdn && !uart_rdn) pulses++;
            if (!prev_rdn && uart_rdn && idx < 4) begin
                idx++;
                bus_in = fifo_bytes[idx];
            end
            prev_rdn = uart_rdn;
        end
        check("fifo: rdn pulses until full", pulses, 4);
        check("fifo: no ack on refill", cnt, 0);
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, 1'b0, 8'h00, 0, 0, lat, rdn_n, wrn_n, rd, ok);
            check($sformatf("fifo read %0d acked", i), lat > 0, 1);
            check($sformatf("fifo read %0d data", i), rd, fifo_bytes[i]);
        end
        repeat (20) @(negedge clk);
        run_txn(1'b0, 1'b0, 8'h00, 0, 0, lat, rdn_n, wrn_n, rd, ok);
        check("fifo read 4 data after refill", rd, 8'h55);
`else
        //          we    addr  wdata  bus_in dr    tbre  tsre  tb  ts  lat rdn wrn chk   exp_rd
        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 0,  0,  2,  0,  0,  1'b1, 8'h03};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 0,  0,  2,  0,  0,  1'b1, 8'h01};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0,  0,  2,  0,  0,  1'b1, 8'h02};
        vecs[3] = '{1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 0,  0,  2,  0,  0,  1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b1, 1'b1, 0,  0,  4,  2,  0,  1'b1, 8'hA5};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b1, 1'b1, 0,  0,  4,  2,  0,  1'b1, 8'h3C};
        vecs[6] = '{1'b1, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b1, 0,  0,  8,  0,  2,  1'b0, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 10, 15, 19, 0,  2,  1'b0, 8'h00};
        vecs[8] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 0,  8,  12, 0,  2,  1'b0, 8'h00};

        for (int i = 0; i < NV; i++) begin
            uart_dataready = vecs[i].dr;
            uart_tbre      = vecs[i].tbre;
            uart_tsre      = vecs[i].tsre;
            bus_in         = vecs[i].bus_in;
            repeat (4) @(negedge clk);
            run_txn(vecs[i].we, vecs[i].addr_sel, vecs[i].wdata, vecs[i].tbre_at, vecs[i].tsre_at,
                    lat, rdn_n, wrn_n, rd, ok);
            check($sformatf("v%0d ack latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d rdn low cycles", i), rdn_n, vecs[i].exp_rdn);
            check($sformatf("v%0d wrn low cycles", i), wrn_n, vecs[i].exp_wrn);
            check($sformatf("v%0d bus framing", i), ok, 1'b1);
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
        end

        // reset in the middle of WR_LOW
        uart_tbre = 1'b1; uart_tsre = 1'b1;
        repeat (3) @(negedge clk);
        req = 1'b1; we = 1'b1; addr_sel = 1'b0; wdata = 8'h77;
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("rst: wrn low before reset", uart_wrn, 1'b0);
        rst = 1'b1; req = 1'b0;
        #1;
        check("rst: wrn released at once", uart_wrn, 1'b1);
        check("rst: bus_oe released at once", bus_oe, 1'b0);
        check("rst: ram_inhibit released at once", ram_inhibit, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack || !uart_wrn || busy) cnt++;
        end
        check("rst: no ack or activity afterwards", cnt, 0);

        // req held through ack: status read followed by a data read
        uart_dataready = 1'b1; bus_in = 8'hC3;
        repeat (3) @(negedge clk);
        req = 1'b1; we = 1'b0; addr_sel = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        check("b2b: first ack", ack, 1'b1);
        check("b2b: idle during ack", busy, 1'b0);
        addr_sel = 1'b0;
        @(negedge clk);
        check("b2b: busy one cycle after ack", busy, 1'b1);
        check("b2b: rdn low one cycle after ack", uart_rdn, 1'b0);
        lat = -1;
        for (int c = 4; c <= 24; c++) begin
            @(negedge clk);
            if (ack) begin
                lat = c;
                break;
            end
        end
        req = 1'b0;
        check("b2b: second ack cycle", lat, 6);
        check("b2b: second rdata", rdata, 8'hC3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
